// File: rtl/spi_master_multi.sv
// spi_master_multi: SPI master driving N_SLAVES active-low chip selects, with
// runtime CPOL/CPHA selection, a fixed SCLK half-period divider and a
// configurable word width.
//
// Optional feature macro: SPI_MASTER_LSB_FIRST_EN adds i_lsb_first (sampled
// with i_send) to shift LSB first and assemble RX from the MSB downward.
//
// Ports:
//   i_clk, i_rst      clock, synchronous active-high reset
//   i_data, i_send    transmit word and request (accepted while o_busy=0)
//   i_slave, i_mode   target slave index and {CPOL,CPHA}, sampled with i_send
//   o_data            last received word, updated with o_done
//   o_busy            transfer in progress
//   o_done, o_err     completion pulse / rejected-request pulse
//   i_miso, o_mosi    SPI data lines
//   o_sclk, o_ss      SPI clock and active-low slave selects
//   i_lsb_first       (macro only) LSB-first bit order for this transfer
module spi_master_multi #(
  parameter int unsigned BITS     = 28,
  parameter int unsigned N_SLAVES = 4,
  parameter int unsigned CLK_DIV  = 2,
  localparam int unsigned SEL_W   = (N_SLAVES > 1) ? $clog2(N_SLAVES) : 1
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic [BITS-1:0]     i_data,
  input  logic                i_send,
  input  logic [SEL_W-1:0]    i_slave,
  input  logic [1:0]          i_mode,
  output logic [BITS-1:0]     o_data,
  output logic                o_busy,
  output logic                o_done,
  output logic                o_err,
  input  logic                i_miso,
  output logic                o_mosi,
  output logic                o_sclk,
  output logic [N_SLAVES-1:0] o_ss
`ifdef SPI_MASTER_LSB_FIRST_EN
  ,
  input  logic                i_lsb_first
`endif
);

  localparam int unsigned DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned EDGES  = 2 * BITS;
  localparam int unsigned EDGE_W = $clog2(EDGES);
  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [EDGE_W-1:0] EDGE_LAST = EDGE_W'(EDGES - 1);

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_XFER, S_HOLD} state_e;

  state_e               state_q, state_d;
  logic [DIV_W-1:0]     div_q, div_d;
  logic [EDGE_W-1:0]    edge_q, edge_d;
  logic [BITS-1:0]      tx_q, tx_d;
  logic [BITS-1:0]      rx_q, rx_d;
  logic [BITS-1:0]      data_q, data_d;
  logic [N_SLAVES-1:0]  ss_q, ss_d;
  logic                 sclk_q, sclk_d;
  logic                 mosi_q, mosi_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 err_q, err_d;
  logic                 cpha_q, cpha_d;
  logic                 lsb_q, lsb_d;
  logic                 lsb_req;
  logic                 div_last;
  logic                 leading;

`ifdef SPI_MASTER_LSB_FIRST_EN
  assign lsb_req = i_lsb_first;
`else
  assign lsb_req = 1'b0;
`endif

  assign div_last = (div_q == DIV_LAST);
  // Even edge indices are leading edges (away from CPOL).
  assign leading  = ~edge_q[0];

  // Bit presented on MOSI next, depending on bit order.
  function automatic logic next_bit(input logic [BITS-1:0] w, input logic lsb);
    return lsb ? w[0] : w[BITS-1];
  endfunction

  // Discard the bit just presented.
  function automatic logic [BITS-1:0] shift_tx(input logic [BITS-1:0] w, input logic lsb);
    return lsb ? (w >> 1) : (w << 1);
  endfunction

  // Next-state and output computation.
  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    edge_d  = edge_q;
    tx_d    = tx_q;
    rx_d    = rx_q;
    data_d  = data_q;
    ss_d    = ss_q;
    sclk_d  = sclk_q;
    mosi_d  = mosi_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    cpha_d  = cpha_q;
    lsb_d   = lsb_q;

    case (state_q)
      S_IDLE: begin
        div_d  = '0;
        edge_d = '0;
        if (i_send) begin
          if (32'(i_slave) >= N_SLAVES) begin
            err_d = 1'b1;
          end else begin
            state_d = S_SETUP;
            busy_d  = 1'b1;
            cpha_d  = i_mode[0];
            lsb_d   = lsb_req;
            sclk_d  = i_mode[1];
            rx_d    = '0;
            ss_d    = ~(N_SLAVES'(1) << i_slave);
            // CPHA=0 presents the first bit before the first edge.
            if (i_mode[0]) begin
              tx_d = i_data;
            end else begin
              mosi_d = next_bit(i_data, lsb_req);
              tx_d   = shift_tx(i_data, lsb_req);
            end
          end
        end
      end

      S_SETUP: begin
        div_d = div_q + DIV_W'(1);
        if (div_last) begin
          div_d   = '0;
          state_d = S_XFER;
        end
      end

      S_XFER: begin
        div_d = div_q + DIV_W'(1);
        if (div_last) begin
          div_d  = '0;
          sclk_d = ~sclk_q;
          if (leading == cpha_q) begin
            // Shift edge; CPHA=0 has no shift after the final trailing edge.
            if (cpha_q || (edge_q != EDGE_LAST)) begin
              mosi_d = next_bit(tx_q, lsb_q);
              tx_d   = shift_tx(tx_q, lsb_q);
            end
          end else begin
            rx_d = lsb_q ? {i_miso, rx_q[BITS-1:1]} : {rx_q[BITS-2:0], i_miso};
          end
          if (edge_q == EDGE_LAST) begin
            edge_d  = '0;
            state_d = S_HOLD;
          end else begin
            edge_d = edge_q + EDGE_W'(1);
          end
        end
      end

      S_HOLD: begin
        div_d = div_q + DIV_W'(1);
        if (div_last) begin
          div_d   = '0;
          state_d = S_IDLE;
          ss_d    = '1;
          data_d  = rx_q;
          done_d  = 1'b1;
          busy_d  = 1'b0;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      div_q   <= '0;
      edge_q  <= '0;
      tx_q    <= '0;
      rx_q    <= '0;
      data_q  <= '0;
      ss_q    <= '1;
      sclk_q  <= 1'b0;
      mosi_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      cpha_q  <= 1'b0;
      lsb_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      edge_q  <= edge_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      data_q  <= data_d;
      ss_q    <= ss_d;
      sclk_q  <= sclk_d;
      mosi_q  <= mosi_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      cpha_q  <= cpha_d;
      lsb_q   <= lsb_d;
    end
  end

  assign o_data = data_q;
  assign o_busy = busy_q;
  assign o_done = done_q;
  assign o_err  = err_q;
  assign o_mosi = mosi_q;
  assign o_sclk = sclk_q;
  assign o_ss   = ss_q;

endmodule

// File: tb/tb_spi_master_multi.sv
// tb_spi_master_multi: directed self-checking bench for spi_master_multi.
// A 4-slave instance covers reset, loopback, CPOL/CPHA modes against a
// behavioural slave, back-to-back and mid-transfer reset; a 3-slave instance
// covers the out-of-range slave index.
module tb_spi_master_multi;

  localparam int unsigned BITS = 28;
  localparam logic [27:0] SLV_WORD = 28'h0123456;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic        send = 1'b0;
  logic [27:0] data_in = '0;
  logic [1:0]  slave = '0;
  logic [1:0]  mode = '0;
  logic [27:0] data_out;
  logic        busy, done, err, miso, mosi, sclk;
  logic [3:0]  ss;
  logic        lsb_first = 1'b0;
  logic        loopback = 1'b1;

  logic        send2 = 1'b0;
  logic [27:0] data_in2 = '0;
  logic [1:0]  slave2 = '0;
  logic [27:0] data_out2;
  logic        busy2, done2, err2, mosi2, sclk2;
  logic [2:0]  ss2;

  int n_checks = 0;
  int n_fail = 0;

  // Behavioural slave on select 2, returning SLV_WORD MSB first.
  logic [27:0] sl_sh = '0;
  logic        sl_miso = 1'b0;
  logic        prev_ss = 1'b1;
  logic        prev_sclk = 1'b0;

  assign miso = loopback ? mosi : sl_miso;

  spi_master_multi #(.BITS(28), .N_SLAVES(4), .CLK_DIV(2)) dut (
    .i_clk(clk), .i_rst(rst), .i_data(data_in), .i_send(send),
    .i_slave(slave), .i_mode(mode), .o_data(data_out), .o_busy(busy),
    .o_done(done), .o_err(err), .i_miso(miso), .o_mosi(mosi),
    .o_sclk(sclk), .o_ss(ss)
`ifdef SPI_MASTER_LSB_FIRST_EN
    , .i_lsb_first(lsb_first)
`endif
  );

  spi_master_multi #(.BITS(28), .N_SLAVES(3), .CLK_DIV(2)) dut3 (
    .i_clk(clk), .i_rst(rst), .i_data(data_in2), .i_send(send2),
    .i_slave(slave2), .i_mode(2'b00), .o_data(data_out2), .o_busy(busy2),
    .o_done(done2), .o_err(err2), .i_miso(mosi2), .o_mosi(mosi2),
    .o_sclk(sclk2), .o_ss(ss2)
`ifdef SPI_MASTER_LSB_FIRST_EN
    , .i_lsb_first(1'b0)
`endif
  );

  always @(negedge clk) begin
    if (!ss[2]) begin
      if (prev_ss) begin
        sl_sh = SLV_WORD;
        if (!mode[0]) begin
          sl_miso = sl_sh[27];
          sl_sh   = sl_sh << 1;
        end
      end else if (sclk != prev_sclk) begin
        // CPHA=0 shifts on trailing edges, CPHA=1 on leading edges.
        if ((sclk != mode[1]) == mode[0]) begin
          sl_miso = sl_sh[27];
          sl_sh   = sl_sh << 1;
        end
      end
    end
    prev_ss   = ss[2];
    prev_sclk = sclk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start(input logic [27:0] d, input logic [1:0] s, input logic [1:0] m);
    data_in = d;
    slave   = s;
    mode    = m;
    send    = 1'b1;
    tick();
    send    = 1'b0;
  endtask

  task automatic wait_done(input int max_cyc, output int cyc);
    cyc = 0;
    while (!done && cyc < max_cyc) begin
      tick();
      cyc++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    n_checks++; if (ss !== 4'b1111) begin n_fail++; $display("FAIL reset_ss: got %b want 1111", ss); end
    n_checks++; if (sclk !== 1'b0) begin n_fail++; $display("FAIL reset_sclk: got %b want 0", sclk); end
    n_checks++; if (mosi !== 1'b0) begin n_fail++; $display("FAIL reset_mosi: got %b want 0", mosi); end
    n_checks++; if (data_out !== 28'h0) begin n_fail++; $display("FAIL reset_data: got %h want 0", data_out); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_checks++; if ({done, err} !== 2'b00) begin n_fail++; $display("FAIL reset_done_err: got %b want 00", {done, err}); end
    n_checks++; if (ss2 !== 3'b111) begin n_fail++; $display("FAIL reset_ss3: got %b want 111", ss2); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_loopback();
    int cyc = 0;
    int dones = 0;
    bit ss_ok = 1'b1;
    loopback = 1'b1;
    start(28'hA5C3F0E, 2'd0, 2'b00);
    while (busy && cyc < 1000) begin
      if (ss !== 4'b1110) ss_ok = 1'b0;
      cyc++;
      tick();
      if (done) dones++;
    end
    n_checks++; if (cyc != 116) begin n_fail++; $display("FAIL lb_busy_cycles: got %0d want 116", cyc); end
    n_checks++; if (ss_ok !== 1'b1) begin n_fail++; $display("FAIL lb_ss_during: got bad select want 1110"); end
    n_checks++; if (data_out !== 28'hA5C3F0E) begin n_fail++; $display("FAIL lb_data: got %h want a5c3f0e", data_out); end
    repeat (5) begin
      tick();
      if (done) dones++;
    end
    n_checks++; if (dones != 1) begin n_fail++; $display("FAIL lb_done_count: got %0d want 1", dones); end
    n_checks++; if (ss !== 4'b1111) begin n_fail++; $display("FAIL lb_ss_after: got %b want 1111", ss); end
  endtask

  task automatic test_modes();
    int cyc;
    logic cpol;
    loopback = 1'b0;
    for (int m = 1; m < 4; m++) begin
      cpol = (m >= 2);
      start(28'hFEDCBA9, 2'd2, 2'(m));
      n_checks++; if (sclk !== cpol) begin n_fail++; $display("FAIL mode%0d_sclk_setup: got %b want %b", m, sclk, cpol); end
      n_checks++; if (ss !== 4'b1011) begin n_fail++; $display("FAIL mode%0d_ss: got %b want 1011", m, ss); end
      wait_done(1000, cyc);
      n_checks++; if (done !== 1'b1 || data_out !== SLV_WORD) begin n_fail++; $display("FAIL mode%0d_data: got done=%b data=%h want done=1 data=%h", m, done, data_out, SLV_WORD); end
      repeat (3) tick();
      n_checks++; if (sclk !== cpol) begin n_fail++; $display("FAIL mode%0d_sclk_idle: got %b want %b", m, sclk, cpol); end
      n_checks++; if (ss !== 4'b1111) begin n_fail++; $display("FAIL mode%0d_ss_after: got %b want 1111", m, ss); end
    end
    loopback = 1'b1;
  endtask

  task automatic test_bad_index();
    int cyc = 0;
    data_in2 = 28'h1234567;
    slave2   = 2'd1;
    send2    = 1'b1;
    tick();
    send2    = 1'b0;
    n_checks++; if (ss2 !== 3'b101) begin n_fail++; $display("FAIL bad_valid_ss: got %b want 101", ss2); end
    while (!done2 && cyc < 1000) begin
      tick();
      cyc++;
    end
    n_checks++; if (data_out2 !== 28'h1234567) begin n_fail++; $display("FAIL bad_valid_data: got %h want 1234567", data_out2); end
    tick();
    slave2 = 2'd3;
    send2  = 1'b1;
    tick();
    send2  = 1'b0;
    n_checks++; if (err2 !== 1'b1) begin n_fail++; $display("FAIL bad_err_pulse: got %b want 1", err2); end
    n_checks++; if (busy2 !== 1'b0 || ss2 !== 3'b111) begin n_fail++; $display("FAIL bad_idle: got busy=%b ss=%b want busy=0 ss=111", busy2, ss2); end
    tick();
    n_checks++; if (err2 !== 1'b0) begin n_fail++; $display("FAIL bad_err_width: got %b want 0", err2); end
    n_checks++; if (data_out2 !== 28'h1234567 || busy2 !== 1'b0) begin n_fail++; $display("FAIL bad_unchanged: got data=%h busy=%b want 1234567 0", data_out2, busy2); end
  endtask

  task automatic test_back_to_back();
    int cyc;
    int extra = 0;
    loopback = 1'b1;
    data_in  = 28'h5A5A5A5;
    slave    = 2'd1;
    mode     = 2'b00;
    send     = 1'b1;
    tick();
    data_in  = 28'h3C3C3C3;
    wait_done(1000, cyc);
    n_checks++; if (cyc != 116) begin n_fail++; $display("FAIL b2b_first_len: got %0d want 116", cyc); end
    n_checks++; if (done !== 1'b1 || busy !== 1'b0 || data_out !== 28'h5A5A5A5) begin n_fail++; $display("FAIL b2b_first: got done=%b busy=%b data=%h want 1 0 5a5a5a5", done, busy, data_out); end
    tick();
    send = 1'b0;
    n_checks++; if (busy !== 1'b1 || ss !== 4'b1101) begin n_fail++; $display("FAIL b2b_second_accept: got busy=%b ss=%b want 1 1101", busy, ss); end
    wait_done(1000, cyc);
    n_checks++; if (done !== 1'b1 || data_out !== 28'h3C3C3C3) begin n_fail++; $display("FAIL b2b_second: got done=%b data=%h want 1 3c3c3c3", done, data_out); end
    repeat (300) begin
      tick();
      if (done) extra++;
    end
    n_checks++; if (extra != 0 || busy !== 1'b0) begin n_fail++; $display("FAIL b2b_extra: got %0d extra dones busy=%b want 0 0", extra, busy); end
  endtask

  task automatic test_reset_mid();
    int dones = 0;
    start(28'h7777777, 2'd0, 2'b00);
    repeat (19) tick();
    rst = 1'b1;
    tick();
    n_checks++; if (ss !== 4'b1111) begin n_fail++; $display("FAIL mid_ss: got %b want 1111", ss); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL mid_busy: got %b want 0", busy); end
    n_checks++; if (data_out !== 28'h0) begin n_fail++; $display("FAIL mid_data: got %h want 0", data_out); end
    rst = 1'b0;
    if (done) dones++;
    repeat (200) begin
      tick();
      if (done) dones++;
    end
    n_checks++; if (dones != 0) begin n_fail++; $display("FAIL mid_no_done: got %0d want 0", dones); end
  endtask

`ifdef SPI_MASTER_LSB_FIRST_EN
  task automatic test_lsb_first();
    int cyc;
    loopback  = 1'b1;
    lsb_first = 1'b1;
    start(28'h0000001, 2'd0, 2'b00);
    n_checks++; if (mosi !== 1'b1) begin n_fail++; $display("FAIL lsb_first_bit: got %b want 1", mosi); end
    wait_done(1000, cyc);
    n_checks++; if (done !== 1'b1 || data_out !== 28'h0000001) begin n_fail++; $display("FAIL lsb_data: got done=%b data=%h want 1 0000001", done, data_out); end
    lsb_first = 1'b0;
    tick();
  endtask
`endif

  initial begin
    test_reset();
    test_loopback();
    test_modes();
    test_bad_index();
    test_back_to_back();
`ifdef SPI_MASTER_LSB_FIRST_EN
    test_lsb_first();
`endif
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
